// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU sequencer: op codes, FSM state type,
// multiply iteration count.
package valu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_PASS = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_ADDS = 5'b00110;
  localparam logic [4:0] OP_SUBS = 5'b00111;
  localparam logic [4:0] OP_MUL  = 5'b01000;
  localparam logic [4:0] OP_MSW  = 5'b01001;
  localparam logic [4:0] OP_CMP  = 5'b01010;
  localparam logic [4:0] OP_NOP  = 5'b11111;

  localparam int unsigned MUL_CYCLES = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_RESP = 2'd3
  } valu_state_t;

endpackage

// File: rtl/valu_mul_iter.sv
// Iterative signed 64x64 -> 128 multiplier: shift-add on operand magnitudes,
// one multiplier bit per cycle, sign applied on the final iteration.
module valu_mul_iter
  import valu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = valu_pkg::MUL_CYCLES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [63:0]  op_r,
  input  logic [63:0]  op_s,
  output logic         done,
  output logic [127:0] prod
);

  localparam logic [6:0] CNT_LAST = 7'(MUL_CYCLES - 1);

  logic [6:0]   cnt;
  logic         run;
  logic         neg;
  logic [127:0] acc;
  logic [127:0] mcand;
  logic [63:0]  mplier;
  logic [127:0] acc_nxt;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      run    <= 1'b0;
      neg    <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      done   <= 1'b0;
      prod   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Magnitude of -2^63 is 2^63, which still fits in 64 unsigned bits.
        mcand  <= {64'd0, op_r[63] ? -op_r : op_r};
        mplier <= op_s[63] ? -op_s : op_s;
        neg    <= op_r[63] ^ op_s[63];
        acc    <= '0;
        cnt    <= '0;
        run    <= 1'b1;
      end else if (run) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 7'd1;
        if (cnt == CNT_LAST) begin
          run  <= 1'b0;
          done <= 1'b1;
          prod <= neg ? -acc_nxt : acc_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/valu_seq_ctrl.sv
// Two-port round-robin sequencer for the 64-bit vector ALU.
// Define VALU_SEQ_MUL_EN to build in the iterative multiplier and Prod_Hi.
module valu_seq_ctrl
  import valu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = valu_pkg::MUL_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  Req_Valid,
  output logic [1:0]  Req_Ready,
  input  logic [63:0] Req_R0,
  input  logic [63:0] Req_S0,
  input  logic [63:0] Req_R1,
  input  logic [63:0] Req_S1,
  input  logic [4:0]  Req_Op0,
  input  logic [4:0]  Req_Op1,
  output logic [63:0] Alu_R,
  output logic [63:0] Alu_S,
  output logic [4:0]  Alu_Op,
  input  logic [63:0] Alu_Y,
  output logic        Res_Valid,
  input  logic        Res_Ready,
  output logic        Res_Id,
  output logic [63:0] Res_Y,
  output logic        Busy
);

  valu_state_t state, state_nxt;

  logic        last_gnt;
  logic        gnt_id;
  logic        accept;
  logic [63:0] sel_r, sel_s;
  logic [4:0]  sel_op;
  logic        is_mul_op;
  logic        msw_op;
  logic        mul_done;
  logic [63:0] r_q, s_q, res_y_q;
  logic [4:0]  op_q;
  logic        id_q;
  logic [63:0] exec_y;

  // Contention goes to whoever was not granted last; a lone requester always wins.
  assign gnt_id    = (&Req_Valid) ? ~last_gnt : Req_Valid[1];
  assign Req_Ready = (state == S_IDLE && |Req_Valid) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = |(Req_Valid & Req_Ready);

  assign sel_r  = gnt_id ? Req_R1  : Req_R0;
  assign sel_s  = gnt_id ? Req_S1  : Req_S0;
  assign sel_op = gnt_id ? Req_Op1 : Req_Op0;

`ifdef VALU_SEQ_MUL_EN
  logic [127:0] mul_prod;
  logic [63:0]  prod_hi;

  assign is_mul_op = (sel_op == OP_MUL);
  assign msw_op    = (op_q == OP_MSW);

  valu_mul_iter #(
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (accept && is_mul_op),
    .op_r   (sel_r),
    .op_s   (sel_s),
    .done   (mul_done),
    .prod   (mul_prod)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prod_hi <= '0;
    else if (state == S_MUL && mul_done) prod_hi <= mul_prod[127:64];
  end
`else
  logic [63:0] prod_hi;

  assign is_mul_op = 1'b0;
  assign msw_op    = 1'b0;
  assign mul_done  = 1'b1;
  assign prod_hi   = '0;
`endif

  always_comb begin
    Alu_R  = '0;
    Alu_S  = '0;
    Alu_Op = OP_NOP;
    if (state == S_EXEC && !msw_op) begin
      Alu_R  = r_q;
      Alu_S  = s_q;
      Alu_Op = op_q;
    end
  end

  always_comb begin
    exec_y = Alu_Y;
    if (op_q == OP_NOP) exec_y = '0;
    else if (msw_op)    exec_y = prod_hi;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = is_mul_op ? S_MUL : S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_MUL:   if (mul_done) state_nxt = S_RESP;
      S_RESP:  if (Res_Ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      last_gnt <= 1'b1;
      r_q      <= '0;
      s_q      <= '0;
      op_q     <= OP_NOP;
      id_q     <= 1'b0;
      res_y_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_gnt <= gnt_id;
        r_q      <= sel_r;
        s_q      <= sel_s;
        op_q     <= sel_op;
        id_q     <= gnt_id;
      end
      if (state == S_EXEC) res_y_q <= exec_y;
`ifdef VALU_SEQ_MUL_EN
      if (state == S_MUL && mul_done) res_y_q <= mul_prod[63:0];
`endif
    end
  end

  assign Res_Valid = (state == S_RESP);
  assign Res_Id    = id_q;
  assign Res_Y     = res_y_q;
  assign Busy      = (state != S_IDLE);

endmodule

// File: tb/tb_valu_seq_ctrl.sv
// Self-checking bench for valu_seq_ctrl: directed scenarios plus random traffic
// against a transaction-level model. Follows VALU_SEQ_MUL_EN like the design.
module tb_valu_seq_ctrl;
  import valu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  Req_Valid = '0;
  logic [1:0]  Req_Ready;
  logic [63:0] Req_R0 = '0, Req_S0 = '0, Req_R1 = '0, Req_S1 = '0;
  logic [4:0]  Req_Op0 = OP_NOP, Req_Op1 = OP_NOP;
  logic [63:0] Alu_R, Alu_S, Alu_Y;
  logic [4:0]  Alu_Op;
  logic        Res_Valid;
  logic        Res_Ready = 1'b0;
  logic        Res_Id;
  logic [63:0] Res_Y;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the sequencer as seen from outside
  bit          m_busy, m_valid, m_last, m_is_mul, m_id;
  int          m_cnt;
  logic [63:0] m_y, m_prod_hi, m_pend_hi;

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [63:0] r, input logic [63:0] s);
    logic [63:0] t;
    case (op)
      OP_ADD:  return r + s;
      OP_PASS: return s;
      OP_SUB:  return r - s;
      OP_AND:  return r & s;
      OP_OR:   return r | s;
      OP_XOR:  return r ^ s;
      OP_ADDS: begin
        t = r + s;
        if (r[63] == s[63] && t[63] != r[63]) t = r[63] ? 64'h8000000000000000 : 64'h7FFFFFFFFFFFFFFF;
        return t;
      end
      OP_SUBS: begin
        t = r - s;
        if (r[63] != s[63] && t[63] != r[63]) t = r[63] ? 64'h8000000000000000 : 64'h7FFFFFFFFFFFFFFF;
        return t;
      end
      OP_CMP:  return {63'd0, $signed(r) < $signed(s)};
      default: return s;
    endcase
  endfunction

  assign Alu_Y = alu_ref(Alu_Op, Alu_R, Alu_S);

  valu_seq_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_R0(Req_R0), .Req_S0(Req_S0), .Req_R1(Req_R1), .Req_S1(Req_S1),
    .Req_Op0(Req_Op0), .Req_Op1(Req_Op1),
    .Alu_R(Alu_R), .Alu_S(Alu_S), .Alu_Op(Alu_Op), .Alu_Y(Alu_Y),
    .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Res_Id(Res_Id), .Res_Y(Res_Y),
    .Busy(Busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void model_accept(input bit id, input logic [63:0] r, input logic [63:0] s,
                                       input logic [4:0] op);
    logic signed [127:0] p;
    bit handled;
    handled  = 1'b0;
    m_is_mul = 1'b0;
`ifdef VALU_SEQ_MUL_EN
    if (op == OP_MUL) begin
      p = $signed({{64{r[63]}}, r}) * $signed({{64{s[63]}}, s});
      m_y       = p[63:0];
      m_pend_hi = p[127:64];
      m_is_mul  = 1'b1;
      handled   = 1'b1;
    end else if (op == OP_MSW) begin
      m_y     = m_prod_hi;
      handled = 1'b1;
    end
`endif
    if (!handled) m_y = (op == OP_NOP) ? 64'd0 : alu_ref(op, r, s);
    m_id   = id;
    m_last = id;
    m_busy = 1'b1;
    m_cnt  = m_is_mul ? int'(MUL_CYCLES) + 1 : 1;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input logic [1:0] v,
                       input logic [63:0] r0, input logic [63:0] s0, input logic [4:0] o0,
                       input logic [63:0] r1, input logic [63:0] s1, input logic [4:0] o1,
                       input logic rr);
    logic [1:0] exp_rdy;
    bit w;
    @(negedge clk);
    Req_Valid = v;
    Req_R0 = r0; Req_S0 = s0; Req_Op0 = o0;
    Req_R1 = r1; Req_S1 = s1; Req_Op1 = o1;
    Res_Ready = rr;
    #1;
    check_eq("busy", Busy, m_busy);
    check_eq("res_valid", Res_Valid, m_valid);
    if (m_valid) begin
      check_eq("res_y", Res_Y, m_y);
      check_eq("res_id", Res_Id, m_id);
    end
    w = (v == 2'b11) ? !m_last : v[1];
    exp_rdy = (!m_busy && v != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
    check_eq("req_ready", Req_Ready, exp_rdy);
    if (!m_busy || m_valid) begin
      check_eq("alu_op_idle", Alu_Op, OP_NOP);
      check_eq("alu_r_idle", Alu_R, 64'd0);
    end
    if (!m_busy) begin
      if (v != 2'b00) model_accept(w, w ? r1 : r0, w ? s1 : s0, w ? o1 : o0);
    end else if (!m_valid) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        if (m_is_mul) m_prod_hi = m_pend_hi;
      end
    end else if (rr) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end
  endtask

  task automatic issue(input bit id, input logic [63:0] r, input logic [63:0] s,
                       input logic [4:0] op, input logic rr);
    if (id) cycle(2'b10, '0, '0, OP_NOP, r, s, op, rr);
    else    cycle(2'b01, r, s, op, '0, '0, OP_NOP, rr);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) cycle(2'b00, '0, '0, OP_NOP, '0, '0, OP_NOP, rr);
  endtask

  task automatic run_one(input bit id, input logic [63:0] r, input logic [63:0] s, input logic [4:0] op);
    issue(id, r, s, op, 1'b1);
    idle(int'(MUL_CYCLES) + 4, 1'b1);
  endtask

  // Reset asserted asynchronously in the middle of the low phase.
  task automatic do_reset();
    @(negedge clk);
    Req_Valid = 2'b00;
    Res_Ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_busy", Busy, 1'b0);
    check_eq("rst_res_valid", Res_Valid, 1'b0);
    check_eq("rst_res_y", Res_Y, 64'd0);
    check_eq("rst_res_id", Res_Id, 1'b0);
    check_eq("rst_ready_none", Req_Ready, 2'b00);
    Req_Valid = 2'b11;
    #1;
    check_eq("rst_ready_both", Req_Ready, 2'b01);
    Req_Valid = 2'b10;
    #1;
    check_eq("rst_ready_r1", Req_Ready, 2'b10);
    Req_Valid = 2'b00;
    m_busy = 1'b0; m_valid = 1'b0; m_last = 1'b1; m_cnt = 0;
    m_prod_hi = '0; m_pend_hi = '0; m_y = '0; m_id = 1'b0; m_is_mul = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [4:0]  ops [12];
    logic [63:0] edges [5];
    logic [63:0] rnd [4];
    logic [4:0]  o0, o1;
    ops   = '{OP_ADD, OP_PASS, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDS, OP_SUBS,
              OP_MUL, OP_MSW, OP_CMP, OP_NOP};
    edges = '{64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd1};

    do_reset();

    // Contention straight out of reset: requester 0 first, then alternating.
    for (int i = 0; i < 14; i++)
      cycle(2'b11, '0, 64'hA, OP_PASS, '0, 64'hB, OP_PASS, 1'b1);
    idle(4, 1'b1);

    run_one(1'b0, 64'd5, 64'd7, OP_ADD);
    run_one(1'b1, 64'hFFFFFFFFFFFFFFFD, 64'd7, OP_MUL);
    run_one(1'b0, 64'd0, 64'd3, OP_MSW);
    run_one(1'b1, 64'h8000000000000000, 64'h8000000000000000, OP_MUL);
    run_one(1'b1, 64'd0, 64'd9, OP_MSW);
    run_one(1'b0, 64'd1, 64'd2, OP_NOP);
    run_one(1'b0, 64'h7FFFFFFFFFFFFFFF, 64'd1, OP_ADDS);

    // Backpressure: result must hold while Res_Ready stays low.
    issue(1'b0, 64'd100, 64'd23, OP_SUB, 1'b0);
    for (int i = 0; i < 12; i++) cycle(2'b01, 64'd1, 64'd1, OP_ADD, '0, '0, OP_NOP, 1'b0);
    idle(3, 1'b1);

    // Abort mid-operation, then Prod_Hi must read back cleared.
    issue(1'b1, 64'd12345, 64'hFFFFFFFFFFFF0001, OP_MUL, 1'b0);
    idle(31, 1'b0);
    do_reset();
    run_one(1'b0, 64'd0, 64'd77, OP_MSW);
    run_one(1'b1, 64'd40, 64'd2, OP_ADD);

    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < 4; k++)
        rnd[k] = ($urandom_range(0, 4) == 0) ? edges[$urandom_range(0, 4)] : {$urandom(), $urandom()};
      o0 = ($urandom_range(0, 7) == 0) ? OP_MUL : ops[$urandom_range(0, 11)];
      o1 = ($urandom_range(0, 7) == 0) ? OP_MUL : ops[$urandom_range(0, 11)];
      cycle(2'($urandom_range(0, 3)), rnd[0], rnd[1], o0, rnd[2], rnd[3], o1,
            $urandom_range(0, 3) != 0);
    end
    idle(int'(MUL_CYCLES) + 4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
